// File: rtl/tilt_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tilt_cursor_ctrl
// Purpose  : Turns averaged accelerometer tilt into Battleship grid cursor
//            moves. Each axis is box-averaged over 2^AVG_LOG2 samples and
//            passed through a symmetric deadzone. The result gives a step
//            direction per axis. A held direction auto-repeats every
//            REPEAT_AVGS averages. The cursor saturates at 0 and GRID_MAX.
// Ports    : i_clk        - system clock
//            i_rst        - synchronous reset, active-high
//            i_data_x/y   - signed 10-bit tilt samples
//            i_data_valid - one-cycle pulse, both axes valid
//            i_enable     - cursor movement enable (aiming phase)
//            o_cursor_x/y - registered cursor coordinates, 0..GRID_MAX
//            o_moved      - one-cycle pulse when a coordinate changed
// Revision : 1.0 - initial release
// ============================================================================
module tilt_cursor_ctrl #(
    parameter int AVG_LOG2    = 2,
    parameter int DEADZONE    = 64,
    parameter int REPEAT_AVGS = 50,
    parameter int GRID_MAX    = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data_x,
    input  logic [9:0] i_data_y,
    input  logic       i_data_valid,
    input  logic       i_enable,
    output logic [3:0] o_cursor_x,
    output logic [3:0] o_cursor_y,
    output logic       o_moved
);

    // Accumulator has AVG_LOG2 guard bits, so a full window cannot overflow.
    localparam int c_ACC_W = 10 + AVG_LOG2;
    localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_REP_W = (REPEAT_AVGS > 1) ? $clog2(REPEAT_AVGS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_AVGS - 1);
    localparam logic signed [10:0] c_DZ_POS   = 11'(DEADZONE);
    localparam logic signed [10:0] c_DZ_NEG   = 11'(-DEADZONE);
    localparam logic [3:0]         c_GRID_MAX = 4'(GRID_MAX);

    localparam logic [0:0] S_NEUTRAL = 1'b0;
    localparam logic [0:0] S_HOLD    = 1'b1;

    // ------------------------------------------------------------------
    // Box averaging
    // ------------------------------------------------------------------
    logic signed [c_ACC_W-1:0] r_acc_x;
    logic signed [c_ACC_W-1:0] r_acc_y;
    logic        [c_CNT_W-1:0] r_cnt;
    logic signed [9:0]         r_avg_x;
    logic signed [9:0]         r_avg_y;
    logic                      r_avg_valid;

    logic signed [c_ACC_W-1:0] w_smp_x;
    logic signed [c_ACC_W-1:0] w_smp_y;
    logic signed [c_ACC_W-1:0] w_sum_x;
    logic signed [c_ACC_W-1:0] w_sum_y;

    // A size cast of a signed value sign-extends.
    assign w_smp_x = c_ACC_W'($signed(i_data_x));
    assign w_smp_y = c_ACC_W'($signed(i_data_y));
    assign w_sum_x = r_acc_x + w_smp_x;
    assign w_sum_y = r_acc_y + w_smp_y;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_cnt       <= '0;
            r_avg_x     <= '0;
            r_avg_y     <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (i_data_valid) begin
                if (r_cnt == c_CNT_LAST) begin
                    // Arithmetic shift: the mean rounds toward -inf. The
                    // mean of 10-bit samples always fits in 10 bits.
                    r_avg_x     <= 10'(w_sum_x >>> AVG_LOG2);
                    r_avg_y     <= 10'(w_sum_y >>> AVG_LOG2);
                    r_avg_valid <= 1'b1;
                    r_acc_x     <= '0;
                    r_acc_y     <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc_x <= w_sum_x;
                    r_acc_y <= w_sum_y;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Deadzone direction decode. Direction is a {pos,neg} pair per axis.
    // The value at exactly +/-DEADZONE decodes as neutral.
    // ------------------------------------------------------------------
    logic signed [10:0] w_ax;
    logic signed [10:0] w_ay;
    logic               w_dx_pos;
    logic               w_dx_neg;
    logic               w_dy_pos;
    logic               w_dy_neg;
    logic [3:0]         w_dir;

    assign w_ax     = 11'(r_avg_x);
    assign w_ay     = 11'(r_avg_y);
    assign w_dx_pos = (w_ax > c_DZ_POS);
    assign w_dx_neg = (w_ax < c_DZ_NEG);
    assign w_dy_pos = (w_ay > c_DZ_POS);
    assign w_dy_neg = (w_ay < c_DZ_NEG);
    assign w_dir    = {w_dx_pos, w_dx_neg, w_dy_pos, w_dy_neg};

    // ------------------------------------------------------------------
    // Step / auto-repeat FSM
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_REP_W-1:0] r_rep;
    logic [3:0]         r_last_dir;

    logic [0:0]         w_state_nxt;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic [3:0]         w_last_nxt;
    logic               w_step;

    always_comb begin
        w_state_nxt = r_state;
        w_rep_nxt   = r_rep;
        w_last_nxt  = r_last_dir;
        w_step      = 1'b0;
        if (!i_enable) begin
            // Parked in NEUTRAL, so the first qualifying average after
            // enable rises steps immediately.
            w_state_nxt = S_NEUTRAL;
            w_rep_nxt   = '0;
        end else if (r_avg_valid) begin
            case (r_state)
                S_NEUTRAL: begin
                    if (w_dir != 4'b0000) begin
                        w_step      = 1'b1;
                        w_last_nxt  = w_dir;
                        w_rep_nxt   = '0;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_dir == 4'b0000) begin
                        w_state_nxt = S_NEUTRAL;
                        w_rep_nxt   = '0;
                    end else if (w_dir != r_last_dir) begin
                        w_step     = 1'b1;
                        w_last_nxt = w_dir;
                        w_rep_nxt  = '0;
                    end else if (r_rep == c_REP_LAST) begin
                        w_step    = 1'b1;
                        w_rep_nxt = '0;
                    end else begin
                        w_rep_nxt = r_rep + c_REP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_NEUTRAL;
                    w_rep_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cursor update with independent per-axis saturation
    // ------------------------------------------------------------------
    logic [3:0] r_cx;
    logic [3:0] r_cy;
    logic       r_moved;
    logic [3:0] w_next_x;
    logic [3:0] w_next_y;

    always_comb begin
        w_next_x = r_cx;
        w_next_y = r_cy;
        if (w_dx_pos && (r_cx < c_GRID_MAX)) begin
            w_next_x = r_cx + 4'd1;
        end else if (w_dx_neg && (r_cx != 4'd0)) begin
            w_next_x = r_cx - 4'd1;
        end
        if (w_dy_pos && (r_cy < c_GRID_MAX)) begin
            w_next_y = r_cy + 4'd1;
        end else if (w_dy_neg && (r_cy != 4'd0)) begin
            w_next_y = r_cy - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_NEUTRAL;
            r_rep      <= '0;
            r_last_dir <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_moved    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rep      <= w_rep_nxt;
            r_last_dir <= w_last_nxt;
            // A step fully blocked by saturation produces no moved pulse.
            r_moved    <= w_step && ((w_next_x != r_cx) || (w_next_y != r_cy));
            if (w_step) begin
                r_cx <= w_next_x;
                r_cy <= w_next_y;
            end
        end
    end

    assign o_cursor_x = r_cx;
    assign o_cursor_y = r_cy;
    assign o_moved    = r_moved;

endmodule
`default_nettype wire

// File: doc/tilt_cursor_ctrl.md
Name: tilt_cursor_ctrl

Overview:
- Consumes the 10-bit per-axis accelerometer samples and the data-valid pulse from the ADXL345 interface.
- Box-averages each axis, applies a symmetric deadzone and converts tilt into steps of a Battleship grid cursor.
- Steps repeat automatically while tilt is held. The cursor saturates at the grid edges.
- Output feeds the game/VGA logic as registered cursor coordinates plus a one-cycle moved pulse.

Parameters:
- AVG_LOG2, 2: log2 of samples averaged per axis (N = 2^AVG_LOG2).
- DEADZONE, 64: tilt magnitude (signed LSB counts) that must be strictly exceeded to register a direction.
- REPEAT_AVGS, 50: averaged results between auto-repeat steps while the same direction is held (50 = 250 ms at 800 Hz, N=4).
- GRID_MAX, 9: highest cursor coordinate (grid is 0..GRID_MAX on both axes).

Ports:
- i_clk, input, 1: system clock.
- i_rst, input, 1: synchronous reset, active-high.
- i_data_x, input, 10: signed two's-complement X tilt sample.
- i_data_y, input, 10: signed two's-complement Y tilt sample.
- i_data_valid, input, 1: one-cycle pulse; both axes are valid.
- i_enable, input, 1: cursor movement enable (game in aiming phase).
- o_cursor_x, output, 4: cursor column, 0..GRID_MAX.
- o_cursor_y, output, 4: cursor row, 0..GRID_MAX.
- o_moved, output, 1: one-cycle pulse when either coordinate changed.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_cursor_x=0, o_cursor_y=0, o_moved=0, accumulators=0, sample counter=0, repeat counter=0, state=NEUTRAL, last_dir=0.
- Reset mid-average discards the partial sums.
- Accumulation: each i_data_valid adds the sign-extended samples into per-axis signed accumulators of width 10+AVG_LOG2, so no overflow is possible.
- The sample counter runs 0..N-1. On the Nth valid:
  - avg = (acc + sample) >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
  - avg is registered and avg_valid pulses at that edge (T).
  - Accumulators and counter clear.
- Accumulation continues regardless of i_enable.
- Direction decode (combinational on avg), per axis:
  - avg > DEADZONE gives +1.
  - avg < -DEADZONE gives -1.
  - otherwise 0 (±DEADZONE itself is neutral).
  - dir = {dx, dy}.
- FSM, evaluated only when avg_valid is high (edge T+1):
  - NEUTRAL: if dir != 0, step in dir, last_dir <= dir, repeat counter <= 0, go to HOLD. Otherwise stay.
  - HOLD, dir == 0: go to NEUTRAL, repeat counter <= 0.
  - HOLD, dir != last_dir (nonzero): step immediately in the new dir, last_dir <= dir, repeat counter <= 0.
  - HOLD, dir == last_dir: repeat counter increments. At REPEAT_AVGS-1 it steps and the counter returns to 0.
- i_enable low: FSM forced to NEUTRAL, no steps, cursor holds. When i_enable rises, the first qualifying average steps immediately.
- Step rules:
  - x += dx and y += dy, each saturating independently at 0 and GRID_MAX. Diagonal steps are allowed.
  - Positive X tilt increments the column; positive Y tilt increments the row.
- Latency: the Nth i_data_valid is sampled at edge T. Cursor and o_moved update at edge T+1.
- o_moved: high for exactly the one cycle after a step in which at least one coordinate actually changed. A step fully blocked by saturation leaves o_moved low.
- Simultaneous i_data_valid and avg_valid: legal. The FSM uses the registered avg while the new sample accumulates into the cleared accumulator.

Test Plan:
- Averaging and first step: reset, then 4 valids with x=+200, y=0 -> at edge T+1 cursor becomes (1,0), o_moved high for 1 cycle, then 0.
- Auto-repeat (bench REPEAT_AVGS=4): hold x=+200 for 9 averages -> steps on averages 1, 5, 9, ending at cursor (3,0). o_moved pulses exactly 3 times.
- Deadzone boundary: avg x=+64 -> no step and o_moved stays 0. Avg x=+65 -> step to (1,0). Avg y=-65 from row 0 -> saturated, no o_moved.
- Saturation and diagonal: start at (8,8), hold x=+300, y=+300 -> one step to (9,9), then repeats produce no change and o_moved stays 0.
- Arithmetic rounding: samples +300, +300, -300, -300 -> avg 0, no step. Samples -1 ×4 -> avg -1, neutral. Samples -400 ×4 -> avg -400, x decrements, saturating at 0.
- Reset and enable: 2 valids at x=+500, then i_rst, then 4 valids at 0 -> no step and cursor (0,0). With i_enable=0 and x=+500 -> no step. Raising i_enable -> step on the next average.
